// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the external data-memory bus sequencer.
// Holds the bus width defaults, the sequencer state type and the read-latency counter width.
package mem_bus_pkg;

    localparam int MB_ADDR_W = 8;
    localparam int MB_DATA_W = 16;

    // Wide enough for a READ_LAT of up to 3 (counts READ_LAT-1 down to 0).
    localparam int LAT_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } mb_state_t;

    function automatic logic [LAT_CNT_W-1:0] lat_load(input int read_lat);
        return LAT_CNT_W'(read_lat - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection, purely combinational.
// On a tie the requester that did not win last time is chosen; no grant when en is low.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Arbiter and sequencer for the shared external data-memory bus with two requesters.
// Define MEMBUS_TURNAROUND_EN to insert one dead bus cycle (TURN) after every write.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = MB_ADDR_W,
    parameter int DATA_W   = MB_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_load(READ_LAT);

    mb_state_t            state;
    logic                 last_gnt;
    logic                 owner;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [1:0]           gnt;
    logic [1:0]           rvalid;
    logic                 arb_en;
    logic                 grant_any;
    logic                 sel;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // Grants only come out of IDLE, and never while reset is being applied.
    assign arb_en = (state == IDLE) && !rst;

    rr_arb2 u_arb (
        .req      ({r1_req, r0_req}),
        .last_gnt (last_gnt),
        .en       (arb_en),
        .gnt      (gnt)
    );

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign grant_any = |gnt;
    assign sel       = gnt[1];
    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];

    always_comb begin
        sel_we    = r0_we;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        if (sel) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
    end

    // All pad outputs are registered so no request input reaches the pads combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            lat_cnt   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            rvalid    <= 2'b00;
        end else begin
            rvalid <= 2'b00;
            mem_we <= 1'b0;
            mem_oe <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner    <= sel;
                        last_gnt <= sel;
                        mem_addr <= sel_addr;
                        if (sel_we) begin
                            mem_wdata <= sel_wdata;
                            mem_we    <= 1'b1;
                            mem_oe    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= READ;
                        end
                    end
                end
                WRITE: begin
`ifdef MEMBUS_TURNAROUND_EN
                    state <= TURN;
`else
                    state <= IDLE;
`endif
                end
                READ: begin
                    if (lat_cnt == '0) begin
                        rdata         <= mem_rdata;
                        rvalid[owner] <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: a cycle-timeline model checked every cycle plus directed literal checks.
// Honours MEMBUS_TURNAROUND_EN when computing the gap after a write.
module tb_mem_bus_ctrl;

    localparam int READ_LAT = 2;
`ifdef MEMBUS_TURNAROUND_EN
    localparam int WR_GAP = 3;
`else
    localparam int WR_GAP = 2;
`endif
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [7:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [15:0] rdata;
    logic [7:0]  mem_addr;
    logic        mem_we, mem_oe;
    logic [15:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    txn_t q0[$];
    txn_t q1[$];

    // External memory seen by the pads
    logic [15:0] extMem [256];
    bit          extWr  [256];

    // Model state
    logic [15:0] modelMem [256];
    bit          modelWr  [256];
    bit          modelValid = 1'b0;
    bit          pendClear  = 1'b0;
    int          busyUntil  = 0;
    bit          lastWinner = 1'b1;
    logic [7:0]  hAddr  = 8'h00;
    logic [15:0] hWdata = 16'h0000;
    logic [15:0] hRdata = 16'h0000;
    bit          bWe     [DEPTH];
    bit          rv0     [DEPTH];
    bit          rv1     [DEPTH];
    bit          nAddrV  [DEPTH];
    bit          nWdataV [DEPTH];
    bit          nRdataV [DEPTH];
    logic [7:0]  nAddr   [DEPTH];
    logic [15:0] nWdata  [DEPTH];
    logic [15:0] nRdata  [DEPTH];

    mem_bus_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r0_gnt    (r0_gnt),
        .r1_gnt    (r1_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initPat(input logic [7:0] a);
        return (a == 8'h40) ? 16'h1234 : {a ^ 8'h5A, a};
    endfunction

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [15:0] d);
        txn_t t;
        t.we   = we;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    assign mem_rdata = extWr[mem_addr] ? extMem[mem_addr] : initPat(mem_addr);

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            extMem[mem_addr] <= mem_wdata;
            extWr[mem_addr]  <= 1'b1;
        end
    end

    initial begin : cycleCounter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int who, input logic we, input logic [7:0] a, input logic [15:0] d);
        if (who == 0) q0.push_back(mk(we, a, d));
        else          q1.push_back(mk(we, a, d));
    endtask

    task automatic waitGnt(input int who, output int t);
        int n;
        n = 0;
        t = -1;
        forever begin
            @(negedge clk);
            if ((who == 0 && r0_gnt === 1'b1) || (who == 1 && r1_gnt === 1'b1)) begin
                t = cyc;
                return;
            end
            n++;
            if (n >= 40) begin
                total++;
                bad++;
                $display("[TB] FAIL gnt_timeout r%0d: got no grant, expected one within 40 cycles", who);
                return;
            end
        end
    endtask

    // Requester drivers: hold req with the head transaction until a grant is seen.
    initial begin : drv0
        bit g;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 16'h0000;
        forever begin
            @(negedge clk);
            g = r0_gnt;
            @(posedge clk);
            #1;
            if (g && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                r0_req = 1'b1; r0_we = q0[0].we; r0_addr = q0[0].addr; r0_wdata = q0[0].data;
            end else begin
                r0_req = 1'b0;
            end
        end
    end

    initial begin : drv1
        bit g;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 16'h0000;
        forever begin
            @(negedge clk);
            g = r1_gnt;
            @(posedge clk);
            #1;
            if (g && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                r1_req = 1'b1; r1_we = q1[0].we; r1_addr = q1[0].addr; r1_wdata = q1[0].data;
            end else begin
                r1_req = 1'b0;
            end
        end
    end

    // Timeline model: each grant books its bus cycles and result cycle; checked every cycle.
    initial begin : model
        int          c;
        bit          hasWin, win, we;
        logic [7:0]  a;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            c = cyc;
            if (pendClear) begin
                hAddr = 8'h00; hWdata = 16'h0000; hRdata = 16'h0000; pendClear = 1'b0;
            end
            if (nAddrV[c])  hAddr  = nAddr[c];
            if (nWdataV[c]) hWdata = nWdata[c];
            if (nRdataV[c]) hRdata = nRdata[c];

            hasWin = 1'b0;
            win    = 1'b0;
            if (!rst && c >= busyUntil) begin
                if (r0_req && r1_req) begin hasWin = 1'b1; win = ~lastWinner; end
                else if (r0_req)      begin hasWin = 1'b1; win = 1'b0; end
                else if (r1_req)      begin hasWin = 1'b1; win = 1'b1; end
            end
            if (hasWin) begin
                lastWinner = win;
                we = win ? r1_we    : r0_we;
                a  = win ? r1_addr  : r0_addr;
                d  = win ? r1_wdata : r0_wdata;
                nAddrV[c+1] = 1'b1;
                nAddr[c+1]  = a;
                if (we) begin
                    bWe[c+1]     = 1'b1;
                    nWdataV[c+1] = 1'b1;
                    nWdata[c+1]  = d;
                    modelMem[a]  = d;
                    modelWr[a]   = 1'b1;
                    busyUntil    = c + WR_GAP;
                end else begin
                    if (win) rv1[c+READ_LAT+1] = 1'b1;
                    else     rv0[c+READ_LAT+1] = 1'b1;
                    nRdataV[c+READ_LAT+1] = 1'b1;
                    nRdata[c+READ_LAT+1]  = modelWr[a] ? modelMem[a] : initPat(a);
                    busyUntil = c + READ_LAT + 1;
                end
            end

            if (modelValid) begin
                checkOutput("r0_gnt",    32'(r0_gnt),    32'(hasWin && !win));
                checkOutput("r1_gnt",    32'(r1_gnt),    32'(hasWin && win));
                checkOutput("mem_we",    32'(mem_we),    32'(bWe[c]));
                checkOutput("mem_oe",    32'(mem_oe),    32'(bWe[c]));
                checkOutput("mem_addr",  32'(mem_addr),  32'(hAddr));
                checkOutput("mem_wdata", 32'(mem_wdata), 32'(hWdata));
                checkOutput("rdata",     32'(rdata),     32'(hRdata));
                checkOutput("r0_rvalid", 32'(r0_rvalid), 32'(rv0[c]));
                checkOutput("r1_rvalid", 32'(r1_rvalid), 32'(rv1[c]));
            end

            if (rst) begin
                for (int k = 1; k <= 8; k++) begin
                    bWe[c+k] = 1'b0; rv0[c+k] = 1'b0; rv1[c+k] = 1'b0;
                    nAddrV[c+k] = 1'b0; nWdataV[c+k] = 1'b0; nRdataV[c+k] = 1'b0;
                end
                pendClear  = 1'b1;
                busyUntil  = c + 1;
                lastWinner = 1'b1;
                modelValid = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int t, t0, t1;
        int order[$];

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_we",   32'(mem_we),   32'd0);
        checkOutput("rst_mem_oe",   32'(mem_oe),   32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_rdata",    32'(rdata),    32'd0);

        $display("[TB] single write");
        applyStimulus(0, 1'b1, 8'h12, 16'hBEEF);
        waitGnt(0, t);
        @(negedge clk);
        checkOutput("wr_mem_we",    32'(mem_we),    32'd1);
        checkOutput("wr_mem_oe",    32'(mem_oe),    32'd1);
        checkOutput("wr_mem_addr",  32'(mem_addr),  32'h12);
        checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk);
        checkOutput("wr_after_we",  32'(mem_we),    32'd0);
        checkOutput("wr_after_oe",  32'(mem_oe),    32'd0);
        checkOutput("wr_hold_data", 32'(mem_wdata), 32'hBEEF);
        repeat (3) @(negedge clk);

        $display("[TB] single read");
        applyStimulus(1, 1'b0, 8'h40, 16'h0000);
        waitGnt(1, t);
        for (int k = 1; k <= READ_LAT; k++) begin
            @(negedge clk);
            checkOutput("rd_mem_addr", 32'(mem_addr), 32'h40);
            checkOutput("rd_mem_oe",   32'(mem_oe),   32'd0);
        end
        @(negedge clk);
        checkOutput("rd_r1_rvalid", 32'(r1_rvalid), 32'd1);
        checkOutput("rd_rdata",     32'(rdata),     32'h1234);
        checkOutput("rd_r0_rvalid", 32'(r0_rvalid), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] contention");
        applyStimulus(0, 1'b1, 8'h20, 16'h1111);
        applyStimulus(0, 1'b0, 8'h21, 16'h0000);
        applyStimulus(0, 1'b1, 8'h22, 16'h2222);
        applyStimulus(0, 1'b0, 8'h12, 16'h0000);
        applyStimulus(1, 1'b0, 8'h40, 16'h0000);
        applyStimulus(1, 1'b1, 8'h21, 16'h3333);
        applyStimulus(1, 1'b0, 8'h20, 16'h0000);
        applyStimulus(1, 1'b1, 8'h30, 16'h4444);
        for (int n = 0; n < 200 && order.size() < 8; n++) begin
            @(negedge clk);
            checkOutput("gnt_onehot", 32'(r0_gnt & r1_gnt), 32'd0);
            if (r0_gnt === 1'b1) order.push_back(0);
            if (r1_gnt === 1'b1) order.push_back(1);
        end
        checkOutput("cont_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8 && i < order.size(); i++)
            checkOutput("cont_order", 32'(order[i]), 32'(i % 2));
        repeat (6) @(negedge clk);

        $display("[TB] write then read");
        applyStimulus(0, 1'b1, 8'h55, 16'hA0A0);
        applyStimulus(1, 1'b0, 8'h55, 16'h0000);
        waitGnt(0, t0);
        waitGnt(1, t1);
        checkOutput("wr_rd_gap", 32'(t1 - t0), 32'(WR_GAP));
        repeat (READ_LAT + 1) @(negedge clk);
        checkOutput("wr_rd_rvalid", 32'(r1_rvalid), 32'd1);
        checkOutput("wr_rd_rdata",  32'(rdata),     32'hA0A0);
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-read");
        applyStimulus(1, 1'b0, 8'h40, 16'h0000);
        waitGnt(1, t);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_mem_addr",  32'(mem_addr),  32'd0);
        checkOutput("abort_mem_we",    32'(mem_we),    32'd0);
        checkOutput("abort_mem_oe",    32'(mem_oe),    32'd0);
        checkOutput("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("abort_rdata",     32'(rdata),     32'd0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("abort_r1_rvalid", 32'(r1_rvalid), 32'd0);
            checkOutput("abort_r0_rvalid", 32'(r0_rvalid), 32'd0);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
